// File: rtl/data_stack_memory_unit.sv
// Single-port data/stack memory: narrow/wide load/store plus push/pop on an internal stack pointer.
// Latency: accept->resp_valid 3 cycles wide, 2 narrow, 1 on error; one request in flight at a time.
// Backpressure: req_ready is high only in IDLE outside reset; the source holds requests until accepted.
// Optional feature macro: DSM_BOUNDS_CHECK_EN (rejects out-of-range load/store addresses).
module data_stack_memory_unit #(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 32,
  parameter int NUM_OF_REGISTER = 11,
  parameter logic [ADDR_WIDTH-1:0] SP_RESET = ADDR_WIDTH'(2**NUM_OF_REGISTER)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic                    req_wide,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic                    resp_valid,
  output logic [2*DATA_WIDTH-1:0] resp_rdata,
  output logic                    resp_err,
  output logic [ADDR_WIDTH-1:0]   sp
);

  localparam int DW = DATA_WIDTH;
  localparam int IW = NUM_OF_REGISTER;
  localparam int D  = 2**NUM_OF_REGISTER;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_PUSH  = 2'b10;
  localparam logic [1:0] OP_POP   = 2'b11;

  typedef enum logic [1:0] {IDLE, FIRST, SECOND, RESP} state_t;

  state_t state, state_nxt;

  logic [DW-1:0] mem [D];

  logic [1:0]              op_q;
  logic                    wide_q;
  logic [IW-1:0]           idx_q;
  logic [IW-1:0]           idx2_q;
  logic [2*DW-1:0]         wdata_q;

  logic                    accept;
  logic                    is_stack;
  logic                    eff_wide;
  logic [ADDR_WIDTH-1:0]   sp_m2;
  logic [ADDR_WIDTH-1:0]   sp_p2;
  logic [IW-1:0]           ea_idx;
  logic                    overflow;
  logic                    underflow;
  logic                    oob;
  logic                    req_err;
  logic                    rd_op_q;
  logic                    wr_op_q;

  assign accept    = req_valid && req_ready;
  assign is_stack  = req_op[1];
  assign eff_wide  = req_wide | is_stack;
  assign sp_m2     = sp - ADDR_WIDTH'(2);
  assign sp_p2     = sp + ADDR_WIDTH'(2);
  assign overflow  = (req_op == OP_PUSH) && (sp < ADDR_WIDTH'(2));
  assign underflow = (req_op == OP_POP) &&
                     (({1'b0, sp} + (ADDR_WIDTH+1)'(2)) > {1'b0, SP_RESET});

`ifdef DSM_BOUNDS_CHECK_EN
  // Load/store must address a word inside the array, and a wide access may not straddle the top.
  assign oob = !is_stack &&
               ((req_addr >= ADDR_WIDTH'(D)) ||
                (req_wide && (req_addr == ADDR_WIDTH'(D-1))));
`else
  // Addresses wrap modulo the depth, so the upper address bits carry no meaning here.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[ADDR_WIDTH-1:IW];
  assign oob = 1'b0;
`endif

  assign req_err = overflow | underflow | oob;

  // Effective word index: pushes pre-decrement, pops read at the current top.
  always_comb begin
    ea_idx = req_addr[IW-1:0];
    case (req_op)
      OP_PUSH: ea_idx = sp_m2[IW-1:0];
      OP_POP:  ea_idx = sp[IW-1:0];
      default: ea_idx = req_addr[IW-1:0];
    endcase
  end

  assign rd_op_q   = (op_q == OP_LOAD) || (op_q == OP_POP);
  assign wr_op_q   = (op_q == OP_STORE) || (op_q == OP_PUSH);
  assign idx2_q    = idx_q + IW'(1);
  assign req_ready = (state == IDLE) && !rst;
  assign resp_valid = (state == RESP);

  // Next-state logic: erroring requests skip the memory phases entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = req_err ? RESP : FIRST;
      FIRST:   state_nxt = wide_q ? SECOND : RESP;
      SECOND:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state, request capture, stack pointer and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sp         <= SP_RESET;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      op_q       <= OP_LOAD;
      wide_q     <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q     <= req_op;
        wide_q   <= eff_wide;
        idx_q    <= ea_idx;
        wdata_q  <= req_wdata;
        resp_err <= req_err;
        if (req_err) begin
          resp_rdata <= '0;
        end else if (req_op == OP_PUSH) begin
          sp <= sp_m2;
        end else if (req_op == OP_POP) begin
          sp <= sp_p2;
        end
      end
      if (state == FIRST) begin
        if (!rd_op_q)    resp_rdata <= '0;
        else if (wide_q) resp_rdata <= {mem[idx_q], {DW{1'b0}}};
        else             resp_rdata <= {{DW{1'b0}}, mem[idx_q]};
      end
      if ((state == SECOND) && rd_op_q) begin
        resp_rdata[DW-1:0] <= mem[idx2_q];
      end
    end
  end

  // Memory writes: high half (or the only word) first, low half to the next index.
  always_ff @(posedge clk) begin
    if (!rst && wr_op_q) begin
      if (state == FIRST) begin
        mem[idx_q] <= wide_q ? wdata_q[2*DW-1:DW] : wdata_q[DW-1:0];
      end
      if (state == SECOND) begin
        mem[idx2_q] <= wdata_q[DW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_data_stack_memory_unit.sv
// Self-checking bench for data_stack_memory_unit: directed scenarios plus a randomized phase.
// Two instances: default stack (SP_RESET = 2048) and a tiny stack (SP_RESET = 4).
// Expected values come from a word-level reference model (associative array + integer sp).
module tb_data_stack_memory_unit;

  localparam int D = 2048;

  logic        clk = 1'b0;
  logic        rst1, rst2;
  logic        vld1, vld2;
  logic [1:0]  op;
  logic        wide;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        rdy1, rv1, rerr1, rdy2, rv2, rerr2;
  logic [31:0] rd1, rd2, sp1, sp2;

  int vectors = 0;
  int fails   = 0;

  logic [15:0] mem_m [int];
  int unsigned sp_m [2];

  int cyc = 0;
  int acc_q [$];
  int resp_n = 0;

  always #5 clk = ~clk;

  data_stack_memory_unit dut1 (
    .clk(clk), .rst(rst1), .req_valid(vld1), .req_ready(rdy1), .req_op(op),
    .req_wide(wide), .req_addr(addr), .req_wdata(wdata), .resp_valid(rv1),
    .resp_rdata(rd1), .resp_err(rerr1), .sp(sp1)
  );

  data_stack_memory_unit #(.SP_RESET(32'd4)) dut2 (
    .clk(clk), .rst(rst2), .req_valid(vld2), .req_ready(rdy2), .req_op(op),
    .req_wide(wide), .req_addr(addr), .req_wdata(wdata), .resp_valid(rv2),
    .resp_rdata(rd2), .resp_err(rerr2), .sp(sp2)
  );

  // Accept / response monitor for the default instance.
  always @(posedge clk) begin
    cyc++;
    if (vld1 && rdy1) acc_q.push_back(cyc);
    if (rv1) resp_n++;
  end

  function automatic int key(input int s, input int idx);
    return s * 4096 + idx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request to instance s, predict with the model, check the response.
  task automatic req(input int s, input logic [1:0] o, input logic w,
                     input logic [31:0] a, input logic [31:0] d);
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        eff_w;
    int          exp_lat, ea, i0, i1, spr, k, budget;
    exp_rd  = 32'h0;
    exp_err = 1'b0;
    eff_w   = w | o[1];
    spr     = (s == 1) ? 4 : D;
    ea      = 0;
    case (o)
      2'b10: if (sp_m[s] < 2) exp_err = 1'b1; else ea = int'(sp_m[s]) - 2;
      2'b11: if (sp_m[s] + 2 > spr) exp_err = 1'b1; else ea = int'(sp_m[s]);
      default: begin
        ea = int'(a % D);
`ifdef DSM_BOUNDS_CHECK_EN
        exp_err = (a >= D) || (w && a == D - 1);
`endif
      end
    endcase
    if (!exp_err) begin
      i0 = ea % D;
      i1 = (ea + 1) % D;
      if (o == 2'b01 || o == 2'b10) begin
        if (eff_w) begin
          mem_m[key(s, i0)] = d[31:16];
          mem_m[key(s, i1)] = d[15:0];
        end else begin
          mem_m[key(s, i0)] = d[15:0];
        end
      end else begin
        exp_rd = eff_w ? {mem_m[key(s, i0)], mem_m[key(s, i1)]} : {16'h0, mem_m[key(s, i0)]};
      end
      if (o == 2'b10) sp_m[s] = sp_m[s] - 2;
      if (o == 2'b11) sp_m[s] = sp_m[s] + 2;
    end
    exp_lat = exp_err ? 1 : (eff_w ? 3 : 2);

    op = o; wide = w; addr = a; wdata = d;
    if (s == 1) vld2 = 1'b1; else vld1 = 1'b1;
    budget = 0;
    while (((s == 1) ? rdy2 : rdy1) !== 1'b1 && budget < 20) begin
      @(posedge clk); #1; budget++;
    end
    if (budget >= 20) chk("ready_timeout", 32'(budget), 32'd0);
    @(posedge clk); #1;
    vld1 = 1'b0; vld2 = 1'b0;
    chk("busy_ready", 32'((s == 1) ? rdy2 : rdy1), 32'd0);
    chk("sp", (s == 1) ? sp2 : sp1, sp_m[s]);
    // k = cycle index (relative to the acceptance edge) whose closing edge sees resp_valid
    k = 1;
    while (((s == 1) ? rv2 : rv1) !== 1'b1 && k < 8) begin
      @(posedge clk); #1; k++;
    end
    chk("latency", 32'(k), 32'(exp_lat));
    chk("resp_err", 32'((s == 1) ? rerr2 : rerr1), 32'(exp_err));
    chk("resp_rdata", (s == 1) ? rd2 : rd1, exp_rd);
    @(posedge clk); #1;
    chk("resp_pulse", 32'((s == 1) ? rv2 : rv1), 32'd0);
  endtask

  initial begin
    int r0, a0, n_acc0, n_resp0;
    logic [31:0] rnd;
    rst1 = 1'b1; rst2 = 1'b1; vld1 = 1'b0; vld2 = 1'b0;
    op = 2'b00; wide = 1'b0; addr = 32'h0; wdata = 32'h0;
    sp_m[0] = D; sp_m[1] = 4;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(rdy1), 32'd0);
    chk("rst_resp_valid", 32'(rv1), 32'd0);
    chk("rst_rdata", rd1, 32'd0);
    chk("rst_err", 32'(rerr1), 32'd0);
    chk("rst_sp", sp1, 32'd2048);
    chk("rst_sp_small", sp2, 32'd4);
    rst1 = 1'b0; rst2 = 1'b0;
    #1;
    chk("ready_after_rst", 32'(rdy1), 32'd1);

    // Wide store / load, narrow load of the low half
    req(0, 2'b01, 1'b1, 32'h10, 32'hDEADBEEF);
    req(0, 2'b00, 1'b1, 32'h10, 32'h0);
    req(0, 2'b00, 1'b0, 32'h11, 32'h0);

    // Stack: two pushes, two pops, then underflow
    req(0, 2'b10, 1'b0, 32'h0, 32'h12345678);
    req(0, 2'b10, 1'b0, 32'h0, 32'h9ABCDEF0);
    req(0, 2'b11, 1'b0, 32'h0, 32'h0);
    req(0, 2'b11, 1'b0, 32'h0, 32'h0);
    req(0, 2'b11, 1'b0, 32'h0, 32'h0);
    chk("sp_after_underflow", sp1, 32'd2048);

    // Tiny stack: overflow on third push, memory untouched by the rejected push
    req(1, 2'b10, 1'b0, 32'h0, 32'h11112222);
    req(1, 2'b10, 1'b0, 32'h0, 32'h33334444);
    req(1, 2'b10, 1'b0, 32'h0, 32'h55556666);
    chk("small_sp_after_overflow", sp2, 32'd0);
    req(1, 2'b00, 1'b1, 32'h0, 32'h0);
    req(1, 2'b00, 1'b1, 32'h2, 32'h0);
    req(1, 2'b11, 1'b0, 32'h0, 32'h0);
    req(1, 2'b11, 1'b0, 32'h0, 32'h0);
    req(1, 2'b11, 1'b0, 32'h0, 32'h0);

    // Wide store at the top word: wraps by default, rejected with bounds checking
    req(0, 2'b01, 1'b0, 32'd2047, 32'h00001111);
    req(0, 2'b01, 1'b0, 32'd0, 32'h00002222);
    req(0, 2'b01, 1'b1, 32'd2047, 32'hAAAA5555);
    req(0, 2'b00, 1'b0, 32'd2047, 32'h0);
    req(0, 2'b00, 1'b0, 32'd0, 32'h0);

    // Reset during SECOND of a wide store
    req(0, 2'b01, 1'b1, 32'h20, 32'h33334444);
    n_resp0 = resp_n;
    op = 2'b01; wide = 1'b1; addr = 32'h20; wdata = 32'h11112222; vld1 = 1'b1;
    @(posedge clk); #1;
    vld1 = 1'b0;
    @(posedge clk); #1;
    rst1 = 1'b1;
    @(posedge clk); #1;
    chk("midrst_resp_valid", 32'(rv1), 32'd0);
    chk("midrst_ready", 32'(rdy1), 32'd0);
    chk("midrst_sp", sp1, 32'd2048);
    rst1 = 1'b0;
    #1;
    chk("midrst_ready_after", 32'(rdy1), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_resp", 32'(resp_n), 32'(n_resp0));
    mem_m[key(0, 32'h20)] = 16'h1111;
    mem_m.delete(key(0, 32'h21));
    sp_m[0] = D;
    req(0, 2'b00, 1'b0, 32'h20, 32'h0);

    // Back-to-back narrow loads with req_valid held high
    n_acc0  = acc_q.size();
    n_resp0 = resp_n;
    op = 2'b00; wide = 1'b0; addr = 32'h10; vld1 = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    vld1 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("b2b_accepts", 32'(acc_q.size() - n_acc0), 32'd5);
    chk("b2b_responses", 32'(resp_n - n_resp0), 32'(acc_q.size() - n_acc0));
    for (int i = n_acc0 + 1; i < acc_q.size(); i++)
      chk("b2b_interval", 32'(acc_q[i] - acc_q[i-1]), 32'd3);
    chk("b2b_rdata", rd1, {16'h0, mem_m[key(0, 32'h10)]});

    // Randomized phase: initialise a low window, then mix load/store/push/pop
    for (int i = 0; i < 16; i += 2) req(0, 2'b01, 1'b1, 32'(i), $urandom);
    for (int n = 0; n < 60; n++) begin
      r0  = int'($urandom_range(0, 3));
      a0  = int'($urandom_range(0, 14));
      rnd = $urandom;
      if (r0 == 2 && sp_m[0] <= 2032) r0 = 3;
      case (r0)
        0: req(0, 2'b00, rnd[0], 32'(a0), 32'h0);
        1: req(0, 2'b01, rnd[0], 32'(a0), $urandom);
        2: req(0, 2'b10, rnd[0], 32'h0, $urandom);
        default: req(0, 2'b11, rnd[0], 32'h0, 32'h0);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/data_stack_memory_unit.md
# data_stack_memory_unit

Clocked, parametrised data/stack memory for the pipeline's memory stage. It replaces the combinational data/stack array with a single-port, request/response block. The block performs 16-bit (narrow) and 32-bit (wide, two-word) loads and stores, and push/pop on an internal stack pointer. It reports stack overflow/underflow (and optionally out-of-range addresses) through a response error flag.

## Interface
- DATA_WIDTH, 16, width of one memory word
- ADDR_WIDTH, 32, width of request address and stack pointer
- NUM_OF_REGISTER, 11, log2 of memory depth; D = 2**NUM_OF_REGISTER words
- SP_RESET, 2**NUM_OF_REGISTER, stack pointer value after reset (empty stack, one past top)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE and not in reset
- req_op  in  2  00 load, 01 store, 10 push, 11 pop
- req_wide  in  1  1 = two-word access, 0 = one word (ignored for push/pop, always wide)
- req_addr  in  ADDR_WIDTH  word address for load/store (ignored for push/pop)
- req_wdata  in  2*DATA_WIDTH  store/push data
- resp_valid  out  1  one-cycle pulse, one per accepted request
- resp_rdata  out  2*DATA_WIDTH  load/pop data, 0 for store/push/error
- resp_err  out  1  qualifies resp_valid; 1 = request rejected, no memory access
- sp  out  ADDR_WIDTH  current stack pointer

## Operation
- Accept on rising edge with req_valid && req_ready; op, wide, address and data are captured.
- Effective address EA:
  - load/store: req_addr
  - push: sp-2
  - pop: sp
- Memory index is EA[NUM_OF_REGISTER-1:0]; the second word index is (EA+1) mod D.
- Wide layout: word[EA] = data[2DW-1:DW], word[EA+1] = data[DW-1:0].
- Narrow store writes req_wdata[DW-1:0] to word[EA]. Narrow load returns {DW'b0, word[EA]}.
- Stack pointer updates at the acceptance edge:
  - push: sp <= sp-2
  - pop: sp <= sp+2
- Overflow: push with sp < 2 -> resp_err, no write, sp unchanged.
- Underflow: pop with sp+2 > SP_RESET -> resp_err, resp_rdata 0, sp unchanged.
- FSM states: IDLE, FIRST, SECOND, RESP.
  - IDLE -> FIRST on accept.
  - IDLE -> RESP on accept of an erroring request.
  - FIRST (access word[EA]) -> SECOND if wide, else RESP.
  - SECOND (access word[EA+1]) -> RESP.
  - RESP (resp_valid=1) -> IDLE.
- Read data is registered into resp_rdata as each word is read. resp_rdata is held until the next RESP.
- Memory contents are not reset.

## Timing
- Reset values: state IDLE, sp=SP_RESET, resp_valid 0, resp_rdata 0, resp_err 0.
- req_ready is 0 while rst is high and 1 in the first cycle after rst deasserts.
- Latency is measured from the acceptance edge n:
  - wide: resp_valid high in cycle n+3..n+4
  - narrow: resp_valid high in cycle n+2..n+3
  - error: resp_valid high in cycle n+1..n+2
- Throughput: the next accept is possible at edge n+4 (wide), n+3 (narrow) or n+2 (error).
- req_ready is low from the acceptance edge until the block returns to IDLE. Requests presented meanwhile are not taken and must be held by the source.
- A pop read returns data written by the preceding push, because the two accesses never overlap.
- Reset mid-operation: the FSM returns to IDLE and no response is issued. A word already written in FIRST stays written. sp returns to SP_RESET.
- Wrap-around without the bounds check: wide access at EA = D-1 writes/reads word[D-1], then word[0].

## Configuration
- DSM_BOUNDS_CHECK_EN defined: a load/store is rejected (resp_err, error timing, no access) when either of these holds:
  - EA >= D
  - wide with EA = D-1
- DSM_BOUNDS_CHECK_EN undefined: addresses are truncated to NUM_OF_REGISTER bits and wrap modulo D. resp_err comes only from stack overflow/underflow.

## Test plan
- Reset, then wide store 0xDEADBEEF at addr 0x10, then wide load 0x10 -> resp_rdata 0xDEADBEEF. Narrow load 0x11 -> 0x0000BEEF. Store resp_valid at n+3 with rdata 0.
- Push 0x12345678, then push 0x9ABCDEF0, then pop, then pop:
  - sp goes 2048 -> 2046 -> 2044 -> 2046 -> 2048.
  - Pops return 0x9ABCDEF0 then 0x12345678.
  - A third pop -> resp_err=1 at n+1, sp stays 2048.
- SP_RESET=4: push, push, push -> third push resp_err=1, sp=0, memory unchanged.
- With DSM_BOUNDS_CHECK_EN: wide store at addr 2047 -> resp_err. Without the macro: same store of 0xAAAA5555 -> word[2047]=0xAAAA, word[0]=0x5555.
- Assert rst in the SECOND cycle of a wide store to 0x20 -> no resp_valid, sp=SP_RESET, req_ready=1 the cycle after rst drops, word[0x20] holds new high half.
- Hold req_valid continuously with back-to-back narrow loads -> accepts exactly every 3 cycles, one resp_valid per request, none lost or duplicated.
